irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_arbiter_if.sv | 31 +++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_arbiter.sv | 85 ++++++++
 tb/tb_irq_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: controller state encoding and
// default sizing for the source vector.
package irq_pkg;

  localparam int N_SRC_DEF = 8;
  localparam int ID_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_arbiter_if.sv
// Interrupt sources/controls towards the arbiter and the request/service view
// back to the core. The arbiter takes the slave side.
interface irq_arbiter_if
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
);

  logic [N_SRC-1:0] i_src;
  logic [N_SRC-1:0] i_mask;
  logic [N_SRC-1:0] i_edge;
  logic             i_ack;
  logic             i_eoi;
  logic             o_irq;
  logic [ID_W-1:0]  o_irq_id;
  logic             o_in_service;
  logic [ID_W-1:0]  o_isr_id;
  logic [N_SRC-1:0] o_pending;

  modport slave (
    input  i_src, i_mask, i_edge, i_ack, i_eoi,
    output o_irq, o_irq_id, o_in_service, o_isr_id, o_pending
  );

  modport master (
    output i_src, i_mask, i_edge, i_ack, i_eoi,
    input  o_irq, o_irq_id, o_in_service, o_isr_id, o_pending
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req and whether any
// bit is set.
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: per-source level/edge pending capture, fixed priority
// selection and a single-level IDLE/REQ/SVC handshake with the core.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  irq_arbiter_if.slave   bus
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [ID_W-1:0]  isr_id_q, isr_id_d;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] ack_clr;
  logic [ID_W-1:0]  enc_id;
  logic             enc_vld;
  logic             ack_take;

  assign eligible = pending_q & ~bus.i_mask;

  irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_enc (
    .req   (eligible),
    .id    (enc_id),
    .valid (enc_vld)
  );

  assign ack_take = (state_q == REQ) && bus.i_ack;
  assign edge_set = bus.i_src & ~prev_q;
  // The ack clears the ID presented this cycle; a fresh edge on it still wins.
  assign ack_clr  = ack_take ? (N_SRC'(1) << irq_id_q) : '0;

  always_comb begin
    state_d   = state_q;
    isr_id_d  = isr_id_q;
    irq_id_d  = enc_id;
    prev_d    = bus.i_src;
    pending_d = (bus.i_edge & (edge_set | (pending_q & ~ack_clr)))
              | (~bus.i_edge & bus.i_src);
    case (state_q)
      IDLE: if (enc_vld) state_d = REQ;
      REQ: begin
        if (bus.i_ack) begin
          state_d  = SVC;
          isr_id_d = irq_id_q;
        end else if (!enc_vld) begin
          state_d = IDLE;
        end
      end
      SVC:     if (bus.i_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      prev_q    <= '0;
      irq_id_q  <= '0;
      isr_id_q  <= '0;
    end else if (en) begin
      state_q   <= state_d;
      pending_q <= pending_d;
      prev_q    <= prev_d;
      irq_id_q  <= irq_id_d;
      isr_id_q  <= isr_id_d;
    end
  end

  assign bus.o_irq        = (state_q == REQ);
  assign bus.o_in_service = (state_q == SVC);
  assign bus.o_irq_id     = irq_id_q;
  assign bus.o_isr_id     = isr_id_q;
  assign bus.o_pending    = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios followed by random traffic, all
// compared each cycle against a behavioural model of the arbitration rules.
module tb_irq_arbiter;

  localparam int NS = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  irq_arbiter_if #(.N_SRC(NS), .ID_W(IW)) bus ();

  irq_arbiter #(.N_SRC(NS), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: pending bits, last sample, "requesting", "handler busy" and IDs.
  logic [NS-1:0] m_pend, m_prev;
  logic          m_irq, m_busy;
  int            m_id, m_isr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [NS-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NS; i++) begin
      if (v[i]) begin
        r = i;
        break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_irq  = 1'b0;
    m_busy = 1'b0;
    m_id   = 0;
    m_isr  = 0;
  endtask

  task automatic model_step();
    logic [NS-1:0] elig, nxt;
    if (!en) return;
    elig = m_pend & ~bus.i_mask;
    for (int i = 0; i < NS; i++) begin
      if (bus.i_edge[i]) begin
        if (bus.i_src[i] && !m_prev[i])         nxt[i] = 1'b1;
        else if (m_irq && bus.i_ack && m_id == i) nxt[i] = 1'b0;
        else                                     nxt[i] = m_pend[i];
      end else begin
        nxt[i] = bus.i_src[i];
      end
    end
    if (m_irq) begin
      if (bus.i_ack) begin
        m_irq  = 1'b0;
        m_busy = 1'b1;
        m_isr  = m_id;
      end else if (elig == 0) begin
        m_irq = 1'b0;
      end
    end else if (m_busy) begin
      if (bus.i_eoi) m_busy = 1'b0;
    end else if (elig != 0) begin
      m_irq = 1'b1;
    end
    m_id   = lowest(elig);
    m_pend = nxt;
    m_prev = bus.i_src;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".irq"},    32'(bus.o_irq),        32'(m_irq));
    chk({tag, ".id"},     32'(bus.o_irq_id),     m_id);
    chk({tag, ".insvc"},  32'(bus.o_in_service), 32'(m_busy));
    chk({tag, ".isr"},    32'(bus.o_isr_id),     m_isr);
    chk({tag, ".pend"},   32'(bus.o_pending),    32'(m_pend));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_src  = '0;
    bus.i_mask = '0;
    bus.i_edge = '0;
    bus.i_ack  = 1'b0;
    bus.i_eoi  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst.irq",   32'(bus.o_irq), 0);
    chk("rst.insvc", 32'(bus.o_in_service), 0);
    chk("rst.id",    32'(bus.o_irq_id), 0);
    chk("rst.isr",   32'(bus.o_isr_id), 0);
    chk("rst.pend",  32'(bus.o_pending), 0);
    rst = 1'b0;

    // Level source 2.
    bus.i_src = 8'h04;
    cyc("lvl1");
    chk("lvl.pend_k", 32'(bus.o_pending), 32'h04);
    chk("lvl.irq_k",  32'(bus.o_irq), 0);
    cyc("lvl2");
    chk("lvl.irq_k1", 32'(bus.o_irq), 1);
    chk("lvl.id",     32'(bus.o_irq_id), 2);
    bus.i_ack = 1'b1;
    cyc("lvl3");
    chk("lvl.insvc",  32'(bus.o_in_service), 1);
    chk("lvl.isr",    32'(bus.o_isr_id), 2);
    bus.i_ack = 1'b0; bus.i_src = '0; bus.i_eoi = 1'b1;
    cyc("lvl4");
    chk("lvl.eoi",    32'(bus.o_in_service), 0);
    bus.i_eoi = 1'b0;

    // Priority with late unmask of source 4.
    bus.i_src = 8'h90; bus.i_mask = 8'h10;
    cyc("pri1");
    cyc("pri2");
    chk("pri.id7", 32'(bus.o_irq_id), 7);
    bus.i_mask = '0;
    cyc("pri3");
    chk("pri.id4", 32'(bus.o_irq_id), 4);
    chk("pri.irq", 32'(bus.o_irq), 1);
    bus.i_ack = 1'b1;
    cyc("pri4");
    chk("pri.isr", 32'(bus.o_isr_id), 4);
    bus.i_ack = 1'b0; bus.i_src = '0; bus.i_eoi = 1'b1;
    cyc("pri5");
    bus.i_eoi = 1'b0;

    // Edge source 3: held pending, cleared by ack, re-set by coincident edge.
    bus.i_edge = 8'h08; bus.i_src = 8'h08;
    cyc("edg1");
    bus.i_src = '0;
    cyc("edg2");
    cyc("edg3");
    chk("edg.held", 32'(bus.o_pending), 32'h08);
    chk("edg.id",   32'(bus.o_irq_id), 3);
    bus.i_ack = 1'b1;
    cyc("edg4");
    chk("edg.clr",  32'(bus.o_pending), 0);
    bus.i_ack = 1'b0; bus.i_eoi = 1'b1;
    cyc("edg5");
    bus.i_eoi = 1'b0; bus.i_src = 8'h08;
    cyc("edg6");
    bus.i_src = '0;
    cyc("edg7");
    bus.i_ack = 1'b1; bus.i_src = 8'h08;
    cyc("edg8");
    chk("edg.setwins", 32'(bus.o_pending), 32'h08);
    chk("edg.insvc",   32'(bus.o_in_service), 1);
    bus.i_ack = 1'b0; bus.i_src = '0; bus.i_eoi = 1'b1;
    cyc("edg9");
    bus.i_eoi = 1'b0;
    cyc("edg10");
    bus.i_ack = 1'b1;
    cyc("edg11");
    bus.i_ack = 1'b0; bus.i_eoi = 1'b1;
    cyc("edg12");
    bus.i_eoi = 1'b0;
    // An edge that rises and falls entirely while en=0 is lost.
    bus.i_edge = 8'h20; en = 1'b0; bus.i_src = 8'h20;
    cyc("lost1");
    en = 1'b1; bus.i_src = '0;
    cyc("lost2");
    chk("lost.pend", 32'(bus.o_pending), 0);
    bus.i_edge = '0;

    // Level drop while requesting.
    bus.i_src = 8'h02;
    cyc("drop1");
    cyc("drop2");
    chk("drop.id", 32'(bus.o_irq_id), 1);
    bus.i_src = '0;
    cyc("drop3");
    cyc("drop4");
    chk("drop.irq", 32'(bus.o_irq), 0);

    // Stray ack/eoi, then clock-enable freeze.
    bus.i_ack = 1'b1;
    cyc("stray1");
    chk("stray.ack_idle", 32'(bus.o_in_service), 0);
    bus.i_ack = 1'b0; bus.i_src = 8'h01;
    cyc("stray2");
    cyc("stray3");
    bus.i_eoi = 1'b1;
    cyc("stray4");
    chk("stray.eoi_req", 32'(bus.o_irq), 1);
    bus.i_eoi = 1'b0;
    en = 1'b0; bus.i_src = '0; bus.i_ack = 1'b1;
    for (int i = 0; i < 3; i++) cyc("frz");
    chk("frz.irq",  32'(bus.o_irq), 1);
    chk("frz.pend", 32'(bus.o_pending), 32'h01);
    en = 1'b1; bus.i_src = 8'h01;
    cyc("svc1");
    chk("svc.insvc", 32'(bus.o_in_service), 1);
    bus.i_ack = 1'b0;

    // Asynchronous reset mid-service.
    #2 rst = 1'b1;
    #1;
    chk("arst.insvc", 32'(bus.o_in_service), 0);
    chk("arst.irq",   32'(bus.o_irq), 0);
    chk("arst.pend",  32'(bus.o_pending), 0);
    chk("arst.isr",   32'(bus.o_isr_id), 0);
    model_reset();
    @(negedge clk);
    check_model("arst");
    rst = 1'b0;
    bus.i_src = '0;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if (c % 64 == 0) bus.i_edge = 8'($urandom);
      bus.i_src  = 8'($urandom) & 8'($urandom);
      bus.i_mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.i_ack  = ($urandom_range(0, 2) == 0);
      bus.i_eoi  = ($urandom_range(0, 2) == 0);
      en         = ($urandom_range(0, 9) != 0);
      cyc("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
